// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: command/response bundle between an initiator and stack_ctrl.
interface stack_ctrl_if #(parameter int WIDTH = 16);
  logic cmd_valid;
  logic cmd_ready;
  logic [2:0] cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] pc_in;
  logic resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic resp_err;
  modport master (
    output cmd_valid, cmd_op, cmd_data, pc_in,
    input cmd_ready, resp_valid, resp_data, resp_err
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_data, pc_in,
    output cmd_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences PUSH/POP/CALL/RET commands onto an external LIFO with fixed 2-cycle response latency.
// Defining STACK_CTRL_PEEK_EN enables the non-destructive PEEK op (op 100).
module stack_ctrl #(
  parameter int WIDTH = 16,
  parameter int RET_INC = 1
) (
  input  logic clock,
  input  logic reset,
  stack_ctrl_if.slave bus,
  output logic lifo_push,
  output logic lifo_pop,
  output logic [WIDTH-1:0] lifo_data,
  input  logic [WIDTH-1:0] lifo_q,
  input  logic lifo_empty,
  input  logic lifo_full,
  output logic [7:0] err_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;
  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_CALL = 3'b010;
  localparam logic [2:0] OP_RET  = 3'b011;
  localparam logic [2:0] OP_PEEK = 3'b100;
  state_t state, next;
  logic [2:0] op;
  logic [WIDTH-1:0] operand, rdata, res_data;
  logic rerr, is_push, is_pop, is_peek, ok, accept;
  always_ff @(posedge clock) state <= reset ? IDLE : next;
  // Outputs are gated by reset so they read zero during the reset cycle itself.
  always_comb begin
    is_push = op == OP_PUSH || op == OP_CALL;
    is_pop = op == OP_POP || op == OP_RET;
`ifdef STACK_CTRL_PEEK_EN
    is_peek = op == OP_PEEK;
`else
    is_peek = 1'b0;
`endif
    ok = is_push ? !lifo_full : (is_pop || is_peek) && !lifo_empty;
    res_data = !ok ? '0 : is_push ? operand : lifo_q;
    bus.cmd_ready = !reset && state == IDLE;
    accept = bus.cmd_ready && bus.cmd_valid;
    lifo_push = !reset && state == ISSUE && is_push && ok;
    lifo_pop = !reset && state == ISSUE && is_pop && ok;
    lifo_data = reset ? '0 : operand;
    bus.resp_valid = !reset && state == SETTLE;
    bus.resp_err = bus.resp_valid && rerr;
    bus.resp_data = reset ? '0 : rdata;
    next = state == IDLE ? (accept ? ISSUE : IDLE) : state == ISSUE ? SETTLE : IDLE;
  end
  always_ff @(posedge clock)
    if (reset) begin
      op <= '0;
      operand <= '0;
      rdata <= '0;
      rerr <= 1'b0;
      err_count <= '0;
    end else begin
      if (accept) begin
        op <= bus.cmd_op;
        operand <= bus.cmd_op == OP_CALL ? bus.pc_in + WIDTH'(RET_INC) : bus.cmd_data;
      end
      if (state == ISSUE) begin
        rdata <= res_data;
        rerr <= !ok;
      end
      if (bus.resp_err && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning the data and address width in bits.
REQ-002 The module SHALL have parameter RET_INC, default 1, meaning the value added to pc_in to form a CALL return address.
REQ-003 The module SHALL have port clock, input, 1 bit, the rising-edge clock.
REQ-004 The module SHALL have port reset, input, 1 bit, a synchronous, active-high reset.
REQ-005 The module SHALL have ports cmd_valid (input, 1 bit) and cmd_ready (output, 1 bit), the command handshake.
REQ-006 The module SHALL have port cmd_op, input, 3 bits: 000 PUSH, 001 POP, 010 CALL, 011 RET, 100 PEEK, others illegal.
REQ-007 The module SHALL have ports cmd_data (input, WIDTH; the PUSH operand) and pc_in (input, WIDTH; the current PC for CALL).
REQ-008 The module SHALL have ports resp_valid (output, 1 bit; a single-cycle pulse), resp_data (output, WIDTH) and resp_err (output, 1 bit).
REQ-009 The module SHALL have ports lifo_push and lifo_pop (outputs, 1 bit each), the stack strobes.
REQ-010 The module SHALL have port lifo_data, output, WIDTH, the value to push.
REQ-011 The module SHALL have ports lifo_q (input, WIDTH; top of stack), lifo_empty and lifo_full (inputs, 1 bit; registered stack flags).
REQ-012 The module SHALL have port err_count, output, 8 bits, a saturating count of error responses.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, ISSUE and SETTLE.
REQ-014 cmd_ready SHALL be 1 only in IDLE.
REQ-015 A command SHALL be accepted on a cycle with cmd_valid=1 and cmd_ready=1; the block SHALL register op and operand, then go IDLE->ISSUE.
REQ-016 In ISSUE the block SHALL evaluate the stored op against lifo_full/lifo_empty, drive at most one strobe for exactly one cycle, then go ISSUE->SETTLE.
REQ-017 In SETTLE the block SHALL assert resp_valid for one cycle, then go SETTLE->IDLE: fixed latency of 2 cycles from acceptance to resp_valid, with a maximum throughput of 1 command per 3 cycles.
REQ-018 PUSH SHALL behave as follows: if lifo_full=0, assert lifo_push with lifo_data=cmd_data and set resp_data=cmd_data, resp_err=0.
REQ-019 CALL SHALL be identical to PUSH, with lifo_data=resp_data=(pc_in+RET_INC) truncated mod 2^WIDTH.
REQ-020 POP and RET SHALL behave as follows: if lifo_empty=0, assert lifo_pop, capture lifo_q in the ISSUE cycle (the pre-pop top) into resp_data, and set resp_err=0.
REQ-021 Overflow SHALL be handled as follows: PUSH/CALL with lifo_full=1 drives no strobe and gives resp_err=1, resp_data=0.
REQ-022 Underflow SHALL be handled as follows: POP/RET with lifo_empty=1 drives no strobe and gives resp_err=1, resp_data=0.
REQ-023 An illegal op SHALL drive no strobe and give resp_err=1, resp_data=0.
REQ-024 lifo_push and lifo_pop SHALL never be asserted together.
REQ-025 lifo_push and lifo_pop SHALL be 0 outside ISSUE.
REQ-026 err_count SHALL increment on each resp_valid with resp_err=1 and saturate at 255.
REQ-027 cmd_valid during ISSUE or SETTLE SHALL be ignored (not accepted), and the inputs SHALL be held by the initiator.

Reset
REQ-028 While reset=1, at each clock edge the FSM SHALL go to IDLE.
REQ-029 While reset=1, cmd_ready, resp_valid, resp_err, lifo_push and lifo_pop SHALL be 0.
REQ-030 While reset=1, resp_data, lifo_data and err_count SHALL be 0.
REQ-031 Reset asserted in ISSUE or SETTLE SHALL abort the command with no resp_valid, and no strobe SHALL appear on the cycle after the reset edge.
REQ-032 cmd_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-033 The preprocessor macro STACK_CTRL_PEEK_EN SHALL control the PEEK op.
REQ-034 With STACK_CTRL_PEEK_EN defined, op 100 SHALL return lifo_q with no strobe and resp_err=0, or resp_err=1, resp_data=0 when lifo_empty=1.
REQ-035 Without STACK_CTRL_PEEK_EN, op 100 SHALL be illegal per REQ-023.

Verification
REQ-036 The bench SHALL cover: reset, then PUSH 0x1234 -> one lifo_push pulse with lifo_data=0x1234, resp_valid 2 cycles after acceptance, resp_data=0x1234, resp_err=0.
REQ-037 The bench SHALL cover: PUSH 0xAAAA then POP -> lifo_pop pulse, resp_data=0xAAAA, resp_err=0.
REQ-038 The bench SHALL cover: CALL with pc_in=0xFFFF, RET_INC=1 -> lifo_data=0x0000; then RET -> resp_data=0x0000.
REQ-039 The bench SHALL cover: POP with lifo_empty=1 -> no strobe, resp_err=1, err_count=1.
REQ-040 The bench SHALL cover: PUSH with lifo_full=1 -> no strobe, resp_err=1, err_count increments.
REQ-041 The bench SHALL cover: reset asserted in the ISSUE cycle of a POP -> no resp_valid, lifo_pop=0 thereafter, cmd_ready=1 after reset is released.
REQ-042 The bench SHALL cover: PEEK with top=0x0055 -> resp_data=0x0055, no strobe when STACK_CTRL_PEEK_EN is defined; resp_err=1 when it is not.
